sseg_scan_arbiter: RTL and testbench
====================================

# sseg_scan_arbiter

Time-multiplexed scan controller and two-requester arbiter for the 4-digit seven-segment LED socket on the FMC mezzanine. It drives the active-low segment bus and the one-hot digit-select lines feeding the FMC pins. Two producers share the display: a priority requester A (alerts and messages) and a default requester B (switch/value display). Grant changes and pattern capture happen only at frame boundaries, and each digit slot begins with a dead-time blank to prevent ghosting.

## Interface
- N_DIG, 4: number of digits scanned.
- REFRESH_DIV, 50000: clock cycles per digit slot; must be ≥ 2.
- BLANK_CYC, 500: blanked cycles at the start of each slot; 0 ≤ BLANK_CYC < REFRESH_DIV.
- MAX_A_FRAMES, 8: consecutive A frames allowed while B is waiting; must be ≥ 1.

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  asynchronous, active-low reset.
- i_req_a  in  1  requester A wants the display (level).
- i_pat_a  in  8*N_DIG  A patterns; digit k = bits [8k+7:8k], active-low {dp,g,f,e,d,c,b,a}.
- i_req_b  in  1  requester B wants the display (level).
- i_pat_b  in  8*N_DIG  B patterns, same format as i_pat_a.
- o_sseg_n  out  8  segment drive, active-low, bit0 = a … bit7 = dp.
- o_ldsel  out  N_DIG  digit select, active-high one-hot; all-zero while blanked.
- o_grant  out  2  one-hot {b,a} owner of the current frame; 00 = nobody.
- o_frame_tick  out  1  single-cycle pulse on the first cycle of each frame.

## Operation
- Slot counter cnt runs 0..REFRESH_DIV-1. Digit index dig advances 0..N_DIG-1 when cnt wraps.
- One frame is N_DIG slots, i.e. N_DIG*REFRESH_DIV cycles.
- Within a slot:
  - For cnt < BLANK_CYC: o_ldsel = 0 and o_sseg_n = 8'hFF.
  - Otherwise: o_ldsel = 1<<dig and o_sseg_n = snap[dig].
- Frame boundary is the last cycle of the frame (cnt = REFRESH_DIV-1, dig = N_DIG-1). On that cycle the block samples i_req_a/b and the patterns:
  - A requesting, and not (B requesting and a_run = MAX_A_FRAMES): grant A, snap ← i_pat_a, a_run ← a_run+1, saturating at MAX_A_FRAMES.
  - Else if B requesting: grant B, snap ← i_pat_b, a_run ← 0.
  - Else: grant none, snap ← all 8'hFF, a_run ← 0.
- Starvation guard: after MAX_A_FRAMES consecutive A frames with B pending, B gets exactly one frame. A may then win again.
- a_run is only compared while B is requesting. With B idle, A holds the display indefinitely.
- Mid-frame changes on req or pat have no visible effect until the next boundary.
- A requester dropping req mid-frame still has its snapshot shown to the end of that frame.
- No tearing: all digits of a frame come from one snapshot.
- Outputs are registered and glitch-free.
- Reset (asynchronous, i_reset = 0):
  - Counters and outputs: cnt = 0, dig = 0, a_run = 0, snap = all 8'hFF.
  - o_sseg_n = 8'hFF, o_ldsel = 0, o_grant = 00, o_frame_tick = 0.
- Reset asserted mid-frame forces the reset values immediately. No partial frame resumes.

## Timing
- Edge 1 is the first rising edge after i_reset deasserts. The cycle after edge 1 is cycle 0 of frame 0 (cnt = 0, dig = 0).
- Frame 0 is always blank with o_grant = 00, and o_frame_tick does not pulse for it.
- o_frame_tick = 1 in cycle 0 of every frame ≥ 1. In that same cycle o_grant and snap already hold the new frame's values.
- o_ldsel and o_sseg_n for cycle c of a slot reflect cnt = c in that cycle.
- Request-to-display latency:
  - Worst case is one full frame plus BLANK_CYC cycles.
  - Best case is BLANK_CYC+1 cycles, when req is asserted on the boundary cycle.
- Counter width is $clog2(REFRESH_DIV). Digit width is $clog2(N_DIG), min 1. Wrap compares use the exact value, with no overflow past REFRESH_DIV-1.
- BLANK_CYC = 0: no blanking, and o_ldsel is one-hot on every cycle of frames ≥ 1 with a grant.

## Test plan
Bench parameters: N_DIG=4, REFRESH_DIV=8, BLANK_CYC=2, MAX_A_FRAMES=2. A frame is 32 cycles.
- **Reset values:** hold i_reset = 0 with random inputs → o_sseg_n = FF, o_ldsel = 0, o_grant = 00, o_frame_tick = 0. Deassert → frame 0 blank for 32 cycles, then o_frame_tick pulses.
- **B-only scan:** i_req_b = 1, i_pat_b = 32'h80_F9_A4_C0 → in frame 1 each slot shows 2 cycles of FF/0000, then 6 cycles of:
  - C0 / 0001, then A4 / 0010, then F9 / 0100, then 80 / 1000.
  - o_grant = 10 throughout.
- **Frame-boundary preemption:** B displaying; raise i_req_a (i_pat_a = all 8'h88) at cycle 10 of a frame → B patterns persist to the frame's end. The next frame shows 88 on all digits with o_grant = 01.
- **Starvation guard:** A and B both held → grant sequence per frame is A, A, B, A, A, B …. With B dropped, A holds every frame.
- **Idle and drop:** drop both requests mid-frame → the current frame completes with its snapshot. The next frame has o_grant = 00, o_sseg_n = FF and o_ldsel = 0 throughout, while o_frame_tick still pulses.
- **Reset mid-operation:** assert i_reset at cycle 13 of an A frame → outputs hit reset values asynchronously, before the next edge. On release, the frame-0 blank sequence repeats exactly.

Source files
------------

// File: rtl/sseg_scan_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sseg_scan_arbiter : 7-seg scan driver with frame-aligned A/B display arbiter
// Revision: 1.0
// ----------------------------------------------------------------------------
module sseg_scan_arbiter #(
   parameter int N_DIG        = 4,
   parameter int REFRESH_DIV  = 50000,
   parameter int BLANK_CYC    = 500,
   parameter int MAX_A_FRAMES = 8
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_req_a,
   input  logic [8*N_DIG-1:0] i_pat_a,
   input  logic               i_req_b,
   input  logic [8*N_DIG-1:0] i_pat_b,
   output logic [7:0]         o_sseg_n,
   output logic [N_DIG-1:0]   o_ldsel,
   output logic [1:0]         o_grant,
   output logic               o_frame_tick
);

   localparam int CNT_W = $clog2(REFRESH_DIV);
   localparam int DIG_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;
   localparam int RUN_W = $clog2(MAX_A_FRAMES + 1);
   localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
   localparam logic [DIG_W-1:0]   DIG_LAST  = DIG_W'(N_DIG - 1);
   localparam logic [RUN_W-1:0]   RUN_MAX   = RUN_W'(MAX_A_FRAMES);
   localparam logic [8*N_DIG-1:0] SNAP_IDLE = {N_DIG{8'hFF}};

   typedef enum logic [1:0] {
      GNT_NONE = 2'b00,
      GNT_A    = 2'b01,
      GNT_B    = 2'b10
   } grant_t;

   logic               run_q,   run_d;
   logic [CNT_W-1:0]   cnt_q,   cnt_d;
   logic [DIG_W-1:0]   dig_q,   dig_d;
   logic [RUN_W-1:0]   a_run_q, a_run_d;
   logic [8*N_DIG-1:0] snap_q,  snap_d;
   grant_t             grant_q, grant_d;
   logic [7:0]         sseg_q,  sseg_d;
   logic [N_DIG-1:0]   ldsel_q, ldsel_d;
   logic               tick_q,  tick_d;
   logic               w_blank;

   // cnt_q/dig_q name the slot position currently on the outputs; run_q holds
   // the first edge after reset so that edge lands on cycle 0 of frame 0.
   always_comb begin
      run_d   = 1'b1;
      cnt_d   = cnt_q;
      dig_d   = dig_q;
      a_run_d = a_run_q;
      snap_d  = snap_q;
      grant_d = grant_q;
      tick_d  = 1'b0;
      if (run_q) begin
         if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (dig_q == DIG_LAST) begin
               dig_d  = '0;
               tick_d = 1'b1;
               if (i_req_a && !(i_req_b && (a_run_q == RUN_MAX))) begin
                  grant_d = GNT_A;
                  snap_d  = i_pat_a;
                  if (a_run_q != RUN_MAX) begin
                     a_run_d = a_run_q + 1'b1;
                  end
               end else if (i_req_b) begin
                  grant_d = GNT_B;
                  snap_d  = i_pat_b;
                  a_run_d = '0;
               end else begin
                  grant_d = GNT_NONE;
                  snap_d  = SNAP_IDLE;
                  a_run_d = '0;
               end
            end else begin
               dig_d = dig_q + 1'b1;
            end
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   generate
      if (BLANK_CYC == 0) begin : g_no_blank
         assign w_blank = 1'b0;
      end else begin : g_blank
         assign w_blank = (cnt_d < CNT_W'(BLANK_CYC));
      end
   endgenerate

   // Outputs are decoded from the next position so they come straight off flops.
   always_comb begin
      sseg_d  = 8'hFF;
      ldsel_d = '0;
      if (!w_blank) begin
         sseg_d = snap_d[{dig_d, 3'b000} +: 8];
         if (grant_d != GNT_NONE) begin
            ldsel_d = N_DIG'(1) << dig_d;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         run_q   <= 1'b0;
         cnt_q   <= '0;
         dig_q   <= '0;
         a_run_q <= '0;
         snap_q  <= SNAP_IDLE;
         grant_q <= GNT_NONE;
         sseg_q  <= 8'hFF;
         ldsel_q <= '0;
         tick_q  <= 1'b0;
      end else begin
         run_q   <= run_d;
         cnt_q   <= cnt_d;
         dig_q   <= dig_d;
         a_run_q <= a_run_d;
         snap_q  <= snap_d;
         grant_q <= grant_d;
         sseg_q  <= sseg_d;
         ldsel_q <= ldsel_d;
         tick_q  <= tick_d;
      end
   end

   assign o_sseg_n     = sseg_q;
   assign o_ldsel      = ldsel_q;
   assign o_grant      = grant_q;
   assign o_frame_tick = tick_q;

endmodule
`default_nettype wire

// File: tb/tb_sseg_scan_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_sseg_scan_arbiter : directed/randomized bench with a frame-level model
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_sseg_scan_arbiter;

   localparam int N_DIG        = 4;
   localparam int REFRESH_DIV  = 8;
   localparam int BLANK_CYC    = 2;
   localparam int MAX_A_FRAMES = 2;
   localparam int FRAME        = N_DIG * REFRESH_DIV;

   logic        clk = 1'b0;
   logic        i_reset = 1'b1;
   logic        i_req_a = 1'b0;
   logic        i_req_b = 1'b0;
   logic [31:0] i_pat_a = '1;
   logic [31:0] i_pat_b = '1;
   logic [7:0]  o_sseg_n;
   logic [3:0]  o_ldsel;
   logic [1:0]  o_grant;
   logic        o_frame_tick;

   always #5 clk = ~clk;

   sseg_scan_arbiter #(
      .N_DIG(N_DIG), .REFRESH_DIV(REFRESH_DIV),
      .BLANK_CYC(BLANK_CYC), .MAX_A_FRAMES(MAX_A_FRAMES)
   ) dut (
      .i_clk(clk), .i_reset(i_reset),
      .i_req_a(i_req_a), .i_pat_a(i_pat_a),
      .i_req_b(i_req_b), .i_pat_b(i_pat_b),
      .o_sseg_n(o_sseg_n), .o_ldsel(o_ldsel),
      .o_grant(o_grant), .o_frame_tick(o_frame_tick)
   );

   int          n_cmp = 0;
   int          n_err = 0;
   // Model: t_m = cycles since the first edge after reset (-1 while in reset).
   int          t_m = -1;
   logic [1:0]  grant_m = 2'b00;
   logic [31:0] snap_m = '1;
   int          a_run_m = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h (t=%0d)", tag, obs, exp, t_m);
      end
   endtask

   task automatic model_edge();
      if (!i_reset) begin
         t_m = -1; grant_m = 2'b00; snap_m = '1; a_run_m = 0;
      end else if (t_m < 0) begin
         t_m = 0;
      end else begin
         if (t_m % FRAME == FRAME - 1) begin
            if (i_req_a && !(i_req_b && a_run_m == MAX_A_FRAMES)) begin
               grant_m = 2'b01; snap_m = i_pat_a;
               a_run_m = (a_run_m < MAX_A_FRAMES) ? a_run_m + 1 : MAX_A_FRAMES;
            end else if (i_req_b) begin
               grant_m = 2'b10; snap_m = i_pat_b; a_run_m = 0;
            end else begin
               grant_m = 2'b00; snap_m = '1; a_run_m = 0;
            end
         end
         t_m++;
      end
   endtask

   task automatic check_outputs();
      int p, cnt, dig;
      logic [7:0] e_sseg;
      logic [3:0] e_ldsel;
      logic       e_tick;
      logic [1:0] e_grant;
      e_sseg = 8'hFF; e_ldsel = 4'b0000; e_tick = 1'b0; e_grant = 2'b00;
      if (t_m >= 0) begin
         p   = t_m % FRAME;
         dig = p / REFRESH_DIV;
         cnt = p % REFRESH_DIV;
         e_tick  = (p == 0) && (t_m >= FRAME);
         e_grant = grant_m;
         if (cnt >= BLANK_CYC) begin
            e_sseg  = snap_m[dig*8 +: 8];
            e_ldsel = (grant_m != 2'b00) ? 4'(1 << dig) : 4'b0000;
         end
      end
      chk("sseg_n", 32'(o_sseg_n), 32'(e_sseg));
      chk("ldsel", 32'(o_ldsel), 32'(e_ldsel));
      chk("grant", 32'(o_grant), 32'(e_grant));
      chk("frame_tick", 32'(o_frame_tick), 32'(e_tick));
   endtask

   task automatic cycle(input bit rnd_pat);
      if (rnd_pat) begin
         i_pat_a = $urandom;
         i_pat_b = $urandom;
      end
      model_edge();
      @(negedge clk);
      check_outputs();
   endtask

   task automatic run(input int n, input bit rnd_pat);
      repeat (n) cycle(rnd_pat);
   endtask

   logic [1:0] seq_exp [6];

   initial begin
      seq_exp[0] = 2'b01; seq_exp[1] = 2'b10; seq_exp[2] = 2'b01;
      seq_exp[3] = 2'b01; seq_exp[4] = 2'b10; seq_exp[5] = 2'b01;

      #1 i_reset = 1'b0;
      repeat (5) begin
         i_req_a = 1'($urandom);
         i_req_b = 1'($urandom);
         cycle(1'b1);
      end

      // B alone: frame 0 blank, frame 1 scans B's digits
      i_req_a = 1'b0; i_req_b = 1'b1;
      i_pat_a = $urandom; i_pat_b = 32'h80F9A4C0;
      i_reset = 1'b1;
      run(32, 1'b0);
      run(1, 1'b0);
      chk("tick_frame1", 32'(o_frame_tick), 32'd1);
      chk("grant_frame1", 32'(o_grant), 32'd2);
      run(2, 1'b0);
      chk("digit0_seg", 32'(o_sseg_n), 32'hC0);
      chk("digit0_sel", 32'(o_ldsel), 32'h1);
      run(29, 1'b0);

      // A rises at cycle 10 of a B frame; takes over on the next frame
      run(11, 1'b0);
      i_req_a = 1'b1; i_pat_a = {4{8'h88}};
      run(21, 1'b0);
      run(3, 1'b0);
      chk("preempt_seg", 32'(o_sseg_n), 32'h88);
      chk("preempt_grant", 32'(o_grant), 32'd1);
      run(29, 1'b1);

      // both requesting: starvation guard interleaves B
      for (int i = 0; i < 6; i++) begin
         run(1, 1'b1);
         chk("starve_seq", 32'(o_grant), 32'(seq_exp[i]));
         run(31, 1'b1);
      end

      // B idle: A keeps every frame
      i_req_b = 1'b0;
      for (int i = 0; i < 4; i++) begin
         run(1, 1'b1);
         chk("a_hold", 32'(o_grant), 32'd1);
         run(31, 1'b1);
      end

      // both drop mid-frame: frame completes, next frame idle
      run(15, 1'b1);
      i_req_a = 1'b0; i_req_b = 1'b0;
      run(17, 1'b1);
      run(1, 1'b1);
      chk("idle_tick", 32'(o_frame_tick), 32'd1);
      run(39, 1'b1);

      // reset at cycle 13 of an A frame
      i_req_a = 1'b1;
      i_req_b = 1'($urandom);
      run(24, 1'b1);
      run(14, 1'b1);
      #1 i_reset = 1'b0;
      #1;
      chk("async_rst_seg", 32'(o_sseg_n), 32'hFF);
      chk("async_rst_sel", 32'(o_ldsel), 32'h0);
      chk("async_rst_grant", 32'(o_grant), 32'h0);
      chk("async_rst_tick", 32'(o_frame_tick), 32'h0);
      run(3, 1'b1);
      i_reset = 1'b1;
      run(70, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
